// File: rtl/dpram_arb_pkg.sv
// Shared constants and helpers for the dual-port RAM arbiter.
// Holds the default geometry and the requester-index width function.
package dpram_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_OUT_DELAY  = 1;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dpram_arb_rr_arb.sv
// Combinational round-robin picker used for both RAM ports.
// The search starts one past the last granted index and wraps to 0.
// 'en' lets the caller veto a grant; a vetoed pick leaves the pointer alone.
module rr_arb
  import dpram_arb_pkg::*;
#(
  parameter int N   = DEF_NUM_REQ,
  parameter int IDW = id_width(DEF_NUM_REQ)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic           found,
  output logic [IDW-1:0] idx,
  output logic [IDW-1:0] ptr_next
);

  // Rotating priority search, then qualify the winner with 'en'.
  always_comb begin
    int             cand;
    logic [IDW-1:0] c;
    cand     = 0;
    c        = '0;
    found    = 1'b0;
    idx      = '0;
    gnt      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      c = IDW'(cand);
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
    if (found && en) gnt[idx] = 1'b1;
    ptr_next = (found && en) ? idx : ptr;
  end

endmodule

// File: rtl/dpram_arb.sv
// Dual-port RAM arbiter: NUM_REQ requesters share one RAM write port and
// one RAM read port, each arbitrated round-robin and independently.
// Read responses are tagged with the owner's index after OUT_DELAY cycles.
// Optional feature: DPRAM_ARB_COLLISION_EN -- when defined, a read that hits
// the address being written in the same cycle is held off for one cycle so
// it returns the new data; otherwise the read returns the old data.
module dpram_arb
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int OUT_DELAY  = DEF_OUT_DELAY,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wr_data,
  output logic [NUM_REQ-1:0]            o_wr_gnt,
  input  logic [NUM_REQ-1:0]            i_rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_REQ-1:0]            o_rd_gnt,
  output logic                          o_rd_valid,
  output logic [ID_W-1:0]               o_rd_id,
  output logic [DATA_WIDTH-1:0]         o_rd_data,
  output logic                          o_ram_we_a,
  output logic [ADDR_WIDTH-1:0]         o_ram_addr_a,
  output logic [DATA_WIDTH-1:0]         o_ram_data_a,
  output logic                          o_ram_en_b,
  output logic [ADDR_WIDTH-1:0]         o_ram_addr_b,
  input  logic [DATA_WIDTH-1:0]         i_ram_data_b
);

  logic [ADDR_WIDTH-1:0] wr_addr_s [NUM_REQ];
  logic [DATA_WIDTH-1:0] wr_data_s [NUM_REQ];
  logic [ADDR_WIDTH-1:0] rd_addr_s [NUM_REQ];

  logic [ID_W-1:0] wr_ptr_reg, wr_ptr_next, wr_idx;
  logic [ID_W-1:0] rd_ptr_reg, rd_ptr_next, rd_idx;
  logic            wr_found, rd_found;
  logic            wr_en, rd_en;
  logic            wr_go, rd_go;

  logic [OUT_DELAY-1:0] vld_sr_reg;
  logic [ID_W-1:0]      id_sr_reg [OUT_DELAY];

  // Unpack the flat per-requester buses into indexable slices.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign wr_addr_s[gi] = i_wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wr_data_s[gi] = i_wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign rd_addr_s[gi] = i_rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  rr_arb #(.N(NUM_REQ), .IDW(ID_W)) u_wr_arb (
    .req      (i_wr_req),
    .ptr      (wr_ptr_reg),
    .en       (wr_en),
    .gnt      (o_wr_gnt),
    .found    (wr_found),
    .idx      (wr_idx),
    .ptr_next (wr_ptr_next)
  );

  rr_arb #(.N(NUM_REQ), .IDW(ID_W)) u_rd_arb (
    .req      (i_rd_req),
    .ptr      (rd_ptr_reg),
    .en       (rd_en),
    .gnt      (o_rd_gnt),
    .found    (rd_found),
    .idx      (rd_idx),
    .ptr_next (rd_ptr_next)
  );

  // Grants are forced off while reset is held.
  assign wr_en = i_rst_n;
  assign wr_go = wr_found & wr_en;

`ifdef DPRAM_ARB_COLLISION_EN
  // Hold the read back when it targets the word being written right now.
  assign rd_en = i_rst_n & ~(wr_go & rd_found & (rd_addr_s[rd_idx] == wr_addr_s[wr_idx]));
`else
  assign rd_en = i_rst_n;
`endif
  assign rd_go = rd_found & rd_en;

  // RAM port drive: winner's slice when granted, zeros otherwise.
  assign o_ram_we_a   = wr_go;
  assign o_ram_addr_a = wr_go ? wr_addr_s[wr_idx] : '0;
  assign o_ram_data_a = wr_go ? wr_data_s[wr_idx] : '0;
  assign o_ram_en_b   = rd_go;
  assign o_ram_addr_b = rd_go ? rd_addr_s[rd_idx] : '0;

  // Read data comes straight from the RAM; validity/ownership from the pipe.
  assign o_rd_data  = i_ram_data_b;
  assign o_rd_valid = vld_sr_reg[OUT_DELAY-1];
  assign o_rd_id    = id_sr_reg[OUT_DELAY-1];

  // Round-robin pointers; reset to the last index so requester 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= ID_W'(NUM_REQ - 1);
      rd_ptr_reg <= ID_W'(NUM_REQ - 1);
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Valid/id shift register matching the RAM read latency; reset drops in-flight reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_sr_reg <= '0;
      for (int i = 0; i < OUT_DELAY; i++) id_sr_reg[i] <= '0;
    end else begin
      vld_sr_reg[0] <= rd_go;
      id_sr_reg[0]  <= rd_idx;
      for (int i = 1; i < OUT_DELAY; i++) begin
        vld_sr_reg[i] <= vld_sr_reg[i-1];
        id_sr_reg[i]  <= id_sr_reg[i-1];
      end
    end
  end

endmodule

// File: tb/tb_dpram_arb.sv
// Self-checking bench for dpram_arb. Two instances (OUT_DELAY 1 and 2) share
// the same stimulus, each with its own behavioural dual-port RAM. A reference
// arbiter/memory model predicts grants and pushes expected responses into a
// per-instance queue; responses are popped and compared as they appear.
module tb_dpram_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    wr_req, rd_req;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*DW-1:0] wr_data;

  logic [N-1:0]  wg1, rg1, wg2, rg2;
  logic          rv1, rv2, we1, we2, en1, en2;
  logic [1:0]    rid1, rid2;
  logic [DW-1:0] rdata1, rdata2, da1, da2, rdb1, rdb2;
  logic [AW-1:0] aa1, aa2, ab1, ab2;

  dpram_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_DELAY(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_gnt(wg1),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_gnt(rg1),
    .o_rd_valid(rv1), .o_rd_id(rid1), .o_rd_data(rdata1),
    .o_ram_we_a(we1), .o_ram_addr_a(aa1), .o_ram_data_a(da1),
    .o_ram_en_b(en1), .o_ram_addr_b(ab1), .i_ram_data_b(rdb1)
  );

  dpram_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_DELAY(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_gnt(wg2),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_gnt(rg2),
    .o_rd_valid(rv2), .o_rd_id(rid2), .o_rd_data(rdata2),
    .o_ram_we_a(we2), .o_ram_addr_a(aa2), .o_ram_data_a(da2),
    .o_ram_en_b(en2), .o_ram_addr_b(ab2), .i_ram_data_b(rdb2)
  );

  // Behavioural dual-port RAMs (read-old-data on same-address collision).
  logic [DW-1:0] mem1 [0:1023];
  logic [DW-1:0] mem2 [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  logic [DW-1:0] rd1_q, rd2_q, rd2_qq;

  always @(posedge clk) begin
    if (we1) mem1[aa1] <= da1;
    if (en1) rd1_q <= mem1[ab1];
    if (we2) mem2[aa2] <= da2;
    if (en2) rd2_q <= mem2[ab2];
    rd2_qq <= rd2_q;
  end
  assign rdb1 = rd1_q;
  assign rdb2 = rd2_qq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wptr = N - 1;
  int rptr = N - 1;
  logic [N-1:0] last_rg;
  resp_t q1[$];
  resp_t q2[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void pick(input logic [N-1:0] req, input int ptr, output bit f, output int idx);
    int c;
    f = 1'b0;
    idx = 0;
    for (int i = 1; i <= N; i++) begin
      c = (ptr + i) % N;
      if (!f && req[c]) begin
        f = 1'b1;
        idx = c;
      end
    end
  endfunction

  task automatic resp_chk(input string tag, input logic v, input logic [1:0] id, input logic [31:0] d,
                          input int qsize, input resp_t front, output bit pop);
    pop = 1'b0;
    if (v) begin
      if (qsize == 0) chk({tag, "_spurious_valid"}, 64'(v), 64'd0);
      else begin
        chk({tag, "_id"}, 64'(id), 64'(front.id));
        chk({tag, "_data"}, 64'(d), 64'(front.data));
        chk({tag, "_latency"}, 64'(cyc), 64'(front.due));
        pop = 1'b1;
      end
    end else if (qsize != 0 && front.due <= cyc) begin
      chk({tag, "_missing_valid"}, 64'(v), 64'd1);
      pop = 1'b1;
    end
  endtask

  // One clock cycle: predict, compare, record, advance.
  task automatic tick();
    bit wf, rf, pop;
    int wi, ri;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [N-1:0] ewg, erg;
    resp_t f;
    @(negedge clk);
    wf = 1'b0; rf = 1'b0; wi = 0; ri = 0; wa = '0; ra = '0; wd = '0; ewg = '0; erg = '0;
    if (rst_n) begin
      pick(wr_req, wptr, wf, wi);
      pick(rd_req, rptr, rf, ri);
    end
    if (wf) begin
      wa = wr_addr[wi*AW +: AW];
      wd = wr_data[wi*DW +: DW];
      ewg[wi] = 1'b1;
    end
    if (rf) begin
      ra = rd_addr[ri*AW +: AW];
`ifdef DPRAM_ARB_COLLISION_EN
      if (wf && ra == wa) rf = 1'b0;
`endif
      if (rf) erg[ri] = 1'b1;
      else ra = '0;
    end
    last_rg = erg;
    $display("cyc %0d rst_n=%0b wr_req=%b rd_req=%b exp_wg=%b exp_rg=%b wg=%b rg=%b rv1=%0b rv2=%0b",
             cyc, rst_n, wr_req, rd_req, ewg, erg, wg1, rg1, rv1, rv2);
    chk("wr_gnt", 64'(wg1), 64'(ewg));
    chk("rd_gnt", 64'(rg1), 64'(erg));
    chk("wr_gnt_d2", 64'(wg2), 64'(ewg));
    chk("rd_gnt_d2", 64'(rg2), 64'(erg));
    chk("ram_we_a", 64'(we1), 64'(wf));
    chk("ram_en_b", 64'(en1), 64'(rf));
    if (wf || !rst_n) begin
      chk("ram_addr_a", 64'(aa1), 64'(wa));
      chk("ram_data_a", 64'(da1), 64'(wd));
    end
    if (rf || !rst_n) chk("ram_addr_b", 64'(ab1), 64'(ra));
    if (!rst_n) begin
      chk("rd_id_rst", 64'(rid1), 64'd0);
      chk("rd_id_rst_d2", 64'(rid2), 64'd0);
    end
    f = (q1.size() != 0) ? q1[0] : '{0, 2'd0, 32'd0};
    resp_chk("rsp_d1", rv1, rid1, rdata1, q1.size(), f, pop);
    if (pop) void'(q1.pop_front());
    f = (q2.size() != 0) ? q2[0] : '{0, 2'd0, 32'd0};
    resp_chk("rsp_d2", rv2, rid2, rdata2, q2.size(), f, pop);
    if (pop) void'(q2.pop_front());
    if (rf) begin
      q1.push_back('{cyc + 1, ri[1:0], ref_mem[ra]});
      q2.push_back('{cyc + 2, ri[1:0], ref_mem[ra]});
    end
    if (wf) ref_mem[wa] = wd;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (wf) wptr = wi;
      if (rf) rptr = ri;
    end else begin
      wptr = N - 1;
      rptr = N - 1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    wr_req = '0;
    rd_req = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
      ref_mem[i] = '0;
    end
    rd1_q = '0; rd2_q = '0; rd2_qq = '0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    last_rg = '0;

    // Reset held with every request asserted: nothing may be granted.
    wr_req = '1;
    rd_req = '1;
    tick();
    tick();
    rst_n = 1'b1;
    idle(1);

    // Write 0xA5A5_0001 to 0x005 by requester 2, then read it back by requester 2.
    wr_addr[2*AW +: AW] = 10'h005;
    wr_data[2*DW +: DW] = 32'hA5A5_0001;
    wr_req = 4'b0100;
    tick();
    wr_req = '0;
    rd_addr[2*AW +: AW] = 10'h005;
    rd_req = 4'b0100;
    tick();
    idle(3);

    // Same-cycle write (req 1) and read (req 3) to 0x3FF.
    wr_addr[1*AW +: AW] = 10'h3FF;
    wr_data[1*DW +: DW] = 32'h0000_1234;
    rd_addr[3*AW +: AW] = 10'h3FF;
    wr_req = 4'b0010;
    rd_req = 4'b1000;
    tick();
    wr_req = '0;
    rd_req = last_rg[3] ? 4'b0000 : 4'b1000;
    tick();
    idle(3);

    // Requesters 0 and 3 write continuously while requester 0 reads back-to-back.
    wr_addr[0*AW +: AW] = 10'h010;
    wr_data[0*DW +: DW] = 32'h1000_0000;
    wr_addr[3*AW +: AW] = 10'h013;
    wr_data[3*DW +: DW] = 32'h3000_0003;
    rd_addr[0*AW +: AW] = 10'h005;
    wr_req = 4'b1001;
    rd_req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) rd_req = '0;
      tick();
    end
    wr_addr[1*AW +: AW] = 10'h011;
    wr_data[1*DW +: DW] = 32'h1111_0001;
    wr_addr[2*AW +: AW] = 10'h012;
    wr_data[2*DW +: DW] = 32'h2222_0002;
    wr_req = 4'b0110;
    tick();
    tick();
    idle(3);

    // Reset pulled one cycle after a read grant: the response must vanish.
    rd_addr[1*AW +: AW] = 10'h3FF;
    rd_req = 4'b0010;
    tick();
    rd_req = '0;
    rst_n = 1'b0;
    q1.delete();
    q2.delete();
    tick();
    tick();
    rst_n = 1'b1;
    idle(3);

    // All four requesters read continuously: grants rotate from requester 0.
    for (int k = 0; k < N; k++) rd_addr[k*AW +: AW] = AW'(16 + k);
    rd_req = 4'b1111;
    for (int i = 0; i < 8; i++) tick();
    idle(3);

    // Random traffic over a small address window.
    for (int i = 0; i < 24; i++) begin
      wr_req = N'($urandom_range(0, 15));
      rd_req = N'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) begin
        wr_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
        rd_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[k*DW +: DW] = $urandom;
      end
      tick();
    end
    idle(4);

    chk("queues_drained", 64'(q1.size() + q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
